// File: rtl/mac_accumulator.sv
// Groups N accepted products from the multiplier into one saturating sum.
// Each completed group sum is held on a valid/ready output until the consumer takes it.
module mac_accumulator #(
    parameter int PW = 32,
    parameter int AW = 40,
    parameter int N  = 8
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_data,
    output logic          out_ovf,
    output logic [7:0]    cnt
);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [7:0] LastCnt = 8'(N - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          ovfSticky_q, ovfSticky_d;
    logic [AW-1:0] outData_q, outData_d;
    logic          outOvf_q, outOvf_d;

    logic [AW:0]   sum;
    logic          cycleOvf;
    logic [AW-1:0] satSum;

    // The carry out of the AW+1 bit sum is exactly the "exceeds 2^AW-1" condition,
    // and a pinned-at-max accumulator keeps carrying out for any nonzero product.
    always_comb begin
        sum      = {1'b0, acc_q} + {{(AW + 1 - PW){1'b0}}, in_data};
        cycleOvf = sum[AW];
        satSum   = cycleOvf ? {AW{1'b1}} : sum[AW-1:0];
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovfSticky_d = ovfSticky_q;
        outData_d   = outData_q;
        outOvf_d    = outOvf_q;

        case (state_q)
            ACC: begin
                if (in_valid) begin
                    if (cnt_q == LastCnt) begin
                        outData_d   = satSum;
                        outOvf_d    = ovfSticky_q | cycleOvf;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovfSticky_d = 1'b0;
                        state_d     = HOLD;
                    end else begin
                        acc_d       = satSum;
                        cnt_d       = cnt_q + 8'd1;
                        ovfSticky_d = ovfSticky_q | cycleOvf;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    // Clear behaves exactly like reset so a discarded group never reaches the output.
    always_ff @(posedge CLK) begin
        if (!RESETn || clear) begin
            state_q     <= ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovfSticky_q <= 1'b0;
            outData_q   <= '0;
            outOvf_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovfSticky_q <= ovfSticky_d;
            outData_q   <= outData_d;
            outOvf_q    <= outOvf_d;
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == HOLD);
    assign out_data  = outData_q;
    assign out_ovf   = outOvf_q;
    assign cnt       = cnt_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: several parameterisations share one stimulus bus,
// and each scenario task resets first and then checks the instance it targets.
module tb_mac_accumulator;

    logic        CLK;
    logic        RESETn;
    logic        clear;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    int compared;
    int mismatched;

    logic        rdyA, vldA, ovfA;
    logic [39:0] dataA;
    logic [7:0]  cntA;
    logic        rdyB, vldB, ovfB;
    logic [39:0] dataB;
    logic [7:0]  cntB;
    logic        rdyC, vldC, ovfC;
    logic [32:0] dataC;
    logic [7:0]  cntC;
    logic        rdyD, vldD, ovfD;
    logic [39:0] dataD;
    logic [7:0]  cntD;
    logic        rdyE, vldE, ovfE;
    logic [39:0] dataE;
    logic [7:0]  cntE;

    mac_accumulator #(.PW(32), .AW(40), .N(4)) uA (
        .CLK(CLK), .RESETn(RESETn), .clear(clear), .in_valid(in_valid), .in_ready(rdyA),
        .in_data(in_data), .out_valid(vldA), .out_ready(out_ready), .out_data(dataA),
        .out_ovf(ovfA), .cnt(cntA));

    mac_accumulator #(.PW(32), .AW(40), .N(3)) uB (
        .CLK(CLK), .RESETn(RESETn), .clear(clear), .in_valid(in_valid), .in_ready(rdyB),
        .in_data(in_data), .out_valid(vldB), .out_ready(out_ready), .out_data(dataB),
        .out_ovf(ovfB), .cnt(cntB));

    mac_accumulator #(.PW(32), .AW(33), .N(4)) uC (
        .CLK(CLK), .RESETn(RESETn), .clear(clear), .in_valid(in_valid), .in_ready(rdyC),
        .in_data(in_data), .out_valid(vldC), .out_ready(out_ready), .out_data(dataC),
        .out_ovf(ovfC), .cnt(cntC));

    mac_accumulator #(.PW(32), .AW(40), .N(8)) uD (
        .CLK(CLK), .RESETn(RESETn), .clear(clear), .in_valid(in_valid), .in_ready(rdyD),
        .in_data(in_data), .out_valid(vldD), .out_ready(out_ready), .out_data(dataD),
        .out_ovf(ovfD), .cnt(cntD));

    mac_accumulator #(.PW(32), .AW(40), .N(1)) uE (
        .CLK(CLK), .RESETn(RESETn), .clear(clear), .in_valid(in_valid), .in_ready(rdyE),
        .in_data(in_data), .out_valid(vldE), .out_ready(out_ready), .out_data(dataE),
        .out_ovf(ovfE), .cnt(cntE));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One clock of stimulus; outputs are stable 1ns after the edge when this returns.
    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic ordy);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset();
        RESETn = 1'b0;
        clear  = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b0);
        RESETn = 1'b1;
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        clear  = 1'b0;
        applyStimulus(1'b1, 32'd77, 1'b0);
        compared++;
        if (vldA !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b expected 0", vldA); end
        compared++;
        if (dataA !== 40'd0) begin mismatched++; $display("[TB] FAIL reset_out_data: got %0h expected 0", dataA); end
        compared++;
        if (ovfA !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_ovf: got %b expected 0", ovfA); end
        compared++;
        if (cntA !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_cnt: got %0d expected 0", cntA); end
        compared++;
        if (rdyA !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b expected 1", rdyA); end
        RESETn = 1'b1;
    endtask

    task automatic test_basic_sum();
        doReset();
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 32'(i), 1'b1);
            compared++;
            if (cntA !== 8'(i)) begin mismatched++; $display("[TB] FAIL basic_cnt: got %0d expected %0d", cntA, i); end
        end
        applyStimulus(1'b1, 32'd4, 1'b1);
        compared++;
        if (vldA !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_out_valid: got %b expected 1", vldA); end
        compared++;
        if (dataA !== 40'd10) begin mismatched++; $display("[TB] FAIL basic_out_data: got %0d expected 10", dataA); end
        compared++;
        if (ovfA !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_out_ovf: got %b expected 0", ovfA); end
        compared++;
        if (cntA !== 8'd0) begin mismatched++; $display("[TB] FAIL basic_cnt_wrap: got %0d expected 0", cntA); end
        compared++;
        if (rdyA !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_in_ready_hold: got %b expected 0", rdyA); end
        applyStimulus(1'b0, 32'd0, 1'b1);
        compared++;
        if (vldA !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_out_valid_drop: got %b expected 0", vldA); end
        compared++;
        if (rdyA !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_in_ready_back: got %b expected 1", rdyA); end
    endtask

    task automatic test_backpressure();
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'd5, 1'b0);
        // Offered products during HOLD must not be taken.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'd99, 1'b0);
            compared++;
            if (vldA !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_out_valid cycle %0d: got %b expected 1", i, vldA); end
            compared++;
            if (dataA !== 40'd20) begin mismatched++; $display("[TB] FAIL bp_out_data cycle %0d: got %0d expected 20", i, dataA); end
            compared++;
            if (rdyA !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_in_ready cycle %0d: got %b expected 0", i, rdyA); end
        end
        applyStimulus(1'b1, 32'd99, 1'b1);
        compared++;
        if (vldA !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_release_valid: got %b expected 0", vldA); end
        compared++;
        if (rdyA !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_release_ready: got %b expected 1", rdyA); end
        compared++;
        if (cntA !== 8'd0) begin mismatched++; $display("[TB] FAIL bp_bubble_cnt: got %0d expected 0", cntA); end
    endtask

    task automatic test_gaps();
        doReset();
        applyStimulus(1'b1, 32'd7, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'd1000, 1'b0);
            compared++;
            if (cntB !== 8'd1) begin mismatched++; $display("[TB] FAIL gap_cnt cycle %0d: got %0d expected 1", i, cntB); end
        end
        applyStimulus(1'b1, 32'd8, 1'b0);
        compared++;
        if (cntB !== 8'd2) begin mismatched++; $display("[TB] FAIL gap_cnt_after: got %0d expected 2", cntB); end
        applyStimulus(1'b1, 32'd9, 1'b0);
        compared++;
        if (vldB !== 1'b1) begin mismatched++; $display("[TB] FAIL gap_out_valid: got %b expected 1", vldB); end
        compared++;
        if (dataB !== 40'd24) begin mismatched++; $display("[TB] FAIL gap_out_data: got %0d expected 24", dataB); end
    endtask

    task automatic test_saturation();
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0);
        compared++;
        if (dataC !== 33'h1_FFFF_FFFF) begin mismatched++; $display("[TB] FAIL sat_out_data: got %0h expected 1ffffffff", dataC); end
        compared++;
        if (ovfC !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_out_ovf: got %b expected 1", ovfC); end
        applyStimulus(1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'd1, 1'b0);
        compared++;
        if (dataC !== 33'd4) begin mismatched++; $display("[TB] FAIL sat_next_data: got %0h expected 4", dataC); end
        compared++;
        if (ovfC !== 1'b0) begin mismatched++; $display("[TB] FAIL sat_next_ovf: got %b expected 0", ovfC); end
    endtask

    task automatic test_reset_clear();
        doReset();
        applyStimulus(1'b1, 32'd10, 1'b0);
        applyStimulus(1'b1, 32'd20, 1'b0);
        RESETn = 1'b0;
        applyStimulus(1'b1, 32'd50, 1'b0);
        RESETn = 1'b1;
        compared++;
        if (cntA !== 8'd0) begin mismatched++; $display("[TB] FAIL rst_mid_cnt: got %0d expected 0", cntA); end
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 32'(i), 1'b0);
        compared++;
        if (dataA !== 40'd10) begin mismatched++; $display("[TB] FAIL rst_mid_data: got %0d expected 10", dataA); end
        applyStimulus(1'b0, 32'd0, 1'b1);

        applyStimulus(1'b1, 32'd10, 1'b0);
        applyStimulus(1'b1, 32'd20, 1'b0);
        clear = 1'b1;
        applyStimulus(1'b1, 32'd50, 1'b0);
        clear = 1'b0;
        compared++;
        if (cntA !== 8'd0) begin mismatched++; $display("[TB] FAIL clr_mid_cnt: got %0d expected 0", cntA); end
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 32'(i), 1'b0);
        compared++;
        if (dataA !== 40'd10) begin mismatched++; $display("[TB] FAIL clr_mid_data: got %0d expected 10", dataA); end
        compared++;
        if (vldA !== 1'b1) begin mismatched++; $display("[TB] FAIL clr_pre_hold: got %b expected 1", vldA); end

        clear = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b0);
        clear = 1'b0;
        compared++;
        if (vldA !== 1'b0) begin mismatched++; $display("[TB] FAIL clr_hold_valid: got %b expected 0", vldA); end
        compared++;
        if (dataA !== 40'd0) begin mismatched++; $display("[TB] FAIL clr_hold_data: got %0d expected 0", dataA); end
        compared++;
        if (rdyA !== 1'b1) begin mismatched++; $display("[TB] FAIL clr_hold_ready: got %b expected 1", rdyA); end
    endtask

    // With in_valid and out_ready held high a group of 4 takes 5 cycles, so 10 edges give two results.
    task automatic test_back_to_back();
        int vldCount;
        doReset();
        vldCount = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'd3, 1'b1);
            if (vldA === 1'b1) begin
                vldCount++;
                compared++;
                if (dataA !== 40'd12) begin mismatched++; $display("[TB] FAIL b2b_data cycle %0d: got %0d expected 12", i, dataA); end
            end
        end
        compared++;
        if (vldCount !== 2) begin mismatched++; $display("[TB] FAIL b2b_group_count: got %0d expected 2", vldCount); end
    endtask

    task automatic test_n1();
        doReset();
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1);
        compared++;
        if (vldE !== 1'b1) begin mismatched++; $display("[TB] FAIL n1_valid: got %b expected 1", vldE); end
        compared++;
        if (dataE !== 40'h00_DEAD_BEEF) begin mismatched++; $display("[TB] FAIL n1_data: got %0h expected deadbeef", dataE); end
        compared++;
        if (cntE !== 8'd0) begin mismatched++; $display("[TB] FAIL n1_cnt: got %0d expected 0", cntE); end
        applyStimulus(1'b1, 32'd5, 1'b1);
        compared++;
        if (vldE !== 1'b0) begin mismatched++; $display("[TB] FAIL n1_bubble: got %b expected 0", vldE); end
        applyStimulus(1'b1, 32'd5, 1'b1);
        compared++;
        if (dataE !== 40'd5) begin mismatched++; $display("[TB] FAIL n1_second_data: got %0d expected 5", dataE); end
    endtask

    task automatic test_multiplier_chain();
        doReset();
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 32'(k * (2 * k)), 1'b0);
            if (k == 7) begin
                compared++;
                if (cntD !== 8'd7) begin mismatched++; $display("[TB] FAIL chain_cnt7: got %0d expected 7", cntD); end
            end
        end
        compared++;
        if (vldD !== 1'b1) begin mismatched++; $display("[TB] FAIL chain_valid: got %b expected 1", vldD); end
        compared++;
        if (dataD !== 40'd408) begin mismatched++; $display("[TB] FAIL chain_data: got %0d expected 408", dataD); end
        compared++;
        if (ovfD !== 1'b0) begin mismatched++; $display("[TB] FAIL chain_ovf: got %b expected 0", ovfD); end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        RESETn     = 1'b1;
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 32'd0;
        out_ready  = 1'b0;
        @(negedge CLK);
        test_reset();
        test_basic_sum();
        test_backpressure();
        test_gaps();
        test_saturation();
        test_reset_clear();
        test_back_to_back();
        test_n1();
        test_multiplier_chain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
